// File: rtl/crc16_pkg.sv
// Shared constants, FSM state type and the single-bit CRC-16 step for the
// frame controller. Length limiting is enabled with CRC16_CTRL_LEN_LIMIT_EN.
package crc16_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned CRC_W   = 16;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned BIT_W   = 3;

  localparam logic [CRC_W-1:0] CRC16_POLY = 16'hBAAD;
  localparam logic [CRC_W-1:0] CRC16_INIT = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } crc16_ctrl_state_t;

  // One LFSR step: feedback is the incoming bit against the current MSB.
  function automatic logic [CRC_W-1:0] crc16_step(input logic [CRC_W-1:0] crc,
                                                  input logic             bit_in);
    logic fb;
    fb = bit_in ^ crc[CRC_W-1];
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC16_POLY : CRC_W'(0));
  endfunction

endpackage

// File: rtl/crc16_serial_engine.sv
// Bit-serial CRC-16 LFSR: synchronous clear, one bit per enabled cycle.
module crc16_serial_engine
  import crc16_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc
);

  logic [CRC_W-1:0] crc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      crc_q <= CRC16_INIT;
    end else if (clr) begin
      crc_q <= CRC16_INIT;
    end else if (shift_en) begin
      crc_q <= crc16_step(crc_q, bit_in);
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/crc16_frame_ctrl.sv
// Two-requester frame controller sharing one serial CRC-16 engine, with
// round-robin grant at frame boundaries. Optional length check: CRC16_CTRL_LEN_LIMIT_EN.
module crc16_frame_ctrl
  import crc16_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      crc_valid,
  input  logic                      crc_ready,
  output logic [CRC_W-1:0]          crc_value,
  output logic                      crc_src,
  output logic [CNT_W-1:0]          byte_cnt,
  output logic                      crc_err
);

  if (MAX_BYTES == 0 || MAX_BYTES > 255) begin : g_max_bytes_range
    $error("crc16_frame_ctrl: MAX_BYTES must be in 1..255");
  end

  crc16_ctrl_state_t  state_q;
  logic               grant_q;
  logic               prio_q;
  logic [BYTE_W-1:0]  byte_q;
  logic               last_q;
  logic [BIT_W-1:0]   bit_cnt_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_REQ-1:0] ready_q;
  logic               valid_q;

  logic               win_c;
  logic               sel_valid_c;
  logic               sel_last_c;
  logic [BYTE_W-1:0]  sel_data_c;
  logic               eng_clr_c;
  logic               eng_shift_c;
  logic               eng_bit_c;

  // Requester that wins an IDLE arbitration: priority holder first.
  assign win_c       = req_valid[prio_q] ? prio_q : ~prio_q;
  assign sel_valid_c = req_valid[grant_q];
  assign sel_last_c  = req_last[grant_q];
  assign sel_data_c  = grant_q ? req_data[2*BYTE_W-1:BYTE_W] : req_data[BYTE_W-1:0];

  assign eng_clr_c   = (state_q == ST_IDLE) && (|req_valid);
  assign eng_bit_c   = byte_q[bit_cnt_q];

`ifdef CRC16_CTRL_LEN_LIMIT_EN
  logic err_q;
  logic drop_q;
  logic cnt_full_c;

  assign cnt_full_c  = (cnt_q == CNT_W'(MAX_BYTES));
  // Bytes past the limit still take their SHIFT slot but leave the CRC frozen.
  assign eng_shift_c = (state_q == ST_SHIFT) && !drop_q;
  assign crc_err     = err_q;
`else
  assign eng_shift_c = (state_q == ST_SHIFT);
  assign crc_err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= 1'b0;
      prio_q    <= 1'b0;
      byte_q    <= '0;
      last_q    <= 1'b0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
      ready_q   <= '0;
      valid_q   <= 1'b0;
`ifdef CRC16_CTRL_LEN_LIMIT_EN
      err_q     <= 1'b0;
      drop_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req_valid) begin
            grant_q <= win_c;
            cnt_q   <= '0;
            ready_q <= {win_c, ~win_c};
            state_q <= ST_LOAD;
`ifdef CRC16_CTRL_LEN_LIMIT_EN
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
`endif
          end
        end

        ST_LOAD: begin
          if (sel_valid_c) begin
            byte_q    <= sel_data_c;
            last_q    <= sel_last_c;
            bit_cnt_q <= BIT_W'(BYTE_W - 1);
            ready_q   <= '0;
            state_q   <= ST_SHIFT;
`ifdef CRC16_CTRL_LEN_LIMIT_EN
            drop_q    <= cnt_full_c;
            if (!cnt_full_c) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
            // Reaching the limit with more bytes still to come is the violation.
            if ((cnt_q == CNT_W'(MAX_BYTES - 1)) && !sel_last_c) begin
              err_q <= 1'b1;
            end
`else
            cnt_q     <= cnt_q + CNT_W'(1);
`endif
          end
        end

        ST_SHIFT: begin
          if (bit_cnt_q == BIT_W'(0)) begin
            if (last_q) begin
              valid_q <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              ready_q <= {grant_q, ~grant_q};
              state_q <= ST_LOAD;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q - BIT_W'(1);
          end
        end

        ST_DONE: begin
          if (crc_ready) begin
            valid_q <= 1'b0;
            prio_q  <= ~grant_q;
            state_q <= ST_IDLE;
`ifdef CRC16_CTRL_LEN_LIMIT_EN
            err_q   <= 1'b0;
`endif
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  crc16_serial_engine u_engine (
    .clk      (clk),
    .reset    (reset),
    .clr      (eng_clr_c),
    .shift_en (eng_shift_c),
    .bit_in   (eng_bit_c),
    .crc      (crc_value)
  );

  assign req_ready = ready_q;
  assign crc_valid = valid_q;
  assign crc_src   = grant_q;
  assign byte_cnt  = cnt_q;

endmodule

// File: tb/tb_crc16_frame_ctrl.sv
// Self-checking bench for crc16_frame_ctrl: directed frames plus randomized
// traffic against a polynomial-division reference and a round-robin model.
`timescale 1ns/1ps
module tb_crc16_frame_ctrl;

`ifdef CRC16_CTRL_LEN_LIMIT_EN
  localparam int TB_MAX = 2;
`else
  localparam int TB_MAX = 64;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic        crc_valid;
  logic        crc_ready;
  logic [15:0] crc_value;
  logic        crc_src;
  logic [7:0]  byte_cnt;
  logic        crc_err;

  always #5 clk = ~clk;

  crc16_frame_ctrl #(.MAX_BYTES(TB_MAX)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .crc_valid (crc_valid),
    .crc_ready (crc_ready),
    .crc_value (crc_value),
    .crc_src   (crc_src),
    .byte_cnt  (byte_cnt),
    .crc_err   (crc_err)
  );

  typedef struct packed { logic [7:0] data; logic last; } tx_t;
  typedef struct packed { logic [15:0] crc; logic [7:0] cnt; logic err; } res_t;

  tx_t        txq0[$];
  tx_t        txq1[$];
  res_t       exq0[$];
  res_t       exq1[$];
  logic [7:0] fbuf[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int owner = -1;
  int prio  = 0;
  int first_hs, last_hs, nb;
  int hold_len, hold_ctr;
  bit dense, rand_ready;
  logic [15:0] cap_crc;
  logic [7:0]  cap_cnt;
  logic        cap_src, cap_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // CRC as remainder of M(x)*x^16 divided by x^16+0xBAAD over the first n bytes.
  function automatic logic [15:0] ref_crc(input int n);
    logic [16:0] rem;
    logic        b;
    rem = '0;
    for (int i = 0; i < n*8 + 16; i++) begin
      b   = (i < n*8) ? fbuf[i/8][7 - (i % 8)] : 1'b0;
      rem = {rem[15:0], b};
      if (rem[16]) rem = rem ^ 17'h1BAAD;
    end
    return rem[15:0];
  endfunction

  task automatic push_frame(input int r, input bit use_exp, input logic [15:0] xc,
                            input logic [7:0] xn, input logic xe);
    res_t e;
    tx_t  t;
    int   n, m;
    n = fbuf.size();
    for (int i = 0; i < n; i++) begin
      t.data = fbuf[i];
      t.last = (i == n - 1);
      if (r == 0) txq0.push_back(t); else txq1.push_back(t);
    end
    if (use_exp) begin
      e.crc = xc; e.cnt = xn; e.err = xe;
    end else begin
`ifdef CRC16_CTRL_LEN_LIMIT_EN
      m     = (n > TB_MAX) ? TB_MAX : n;
      e.err = (n > TB_MAX);
`else
      m     = n;
      e.err = 1'b0;
`endif
      e.cnt = 8'(m % 256);
      e.crc = ref_crc(m);
    end
    if (r == 0) exq0.push_back(e); else exq1.push_back(e);
  endtask

  task automatic drive();
    tx_t        h0, h1;
    logic [1:0] v;
    h0 = '0;
    h1 = '0;
    if (txq0.size() > 0) h0 = txq0[0];
    if (txq1.size() > 0) h1 = txq1[0];
    v[0] = (txq0.size() > 0) && (dense || $urandom_range(0, 3) != 0);
    v[1] = (txq1.size() > 0) && (dense || $urandom_range(0, 3) != 0);
    req_valid = v;
    req_data  = {h1.data, h0.data};
    req_last  = {h1.last, h0.last};
    if (crc_valid && hold_ctr > 0) begin
      crc_ready = 1'b0;
      hold_ctr--;
    end else begin
      crc_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic step();
    logic [1:0] pv, pr, mask;
    logic       pcv, pcr;
    tx_t        t;
    res_t       e;
    int         g;
    pv = req_valid; pr = req_ready; pcv = crc_valid; pcr = crc_ready;
    @(posedge clk); #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (pv[i] && pr[i]) begin
        if (i == 0) t = txq0.pop_front(); else t = txq1.pop_front();
        if (nb == 0) first_hs = cyc;
        nb++;
        if (t.last) last_hs = cyc;
      end
    end
    if (pcv && pcr) begin
      if (owner == 0) void'(exq0.pop_front());
      else if (owner == 1) void'(exq1.pop_front());
      prio  = 1 - owner;
      owner = -1;
      nb    = 0;
    end
    if (owner < 0) begin
      if (req_ready != 2'b00) begin
        g    = pv[prio] ? prio : 1 - prio;
        mask = 2'b01 << g;
        chk("grant", 32'(req_ready), 32'(mask));
        owner = g;
        nb    = 0;
      end
    end else begin
      mask = 2'b01 << owner;
      chk("ready_owner", 32'(req_ready & ~mask), 32'd0);
    end
    if (crc_valid) begin
      if (owner < 0 || (owner == 0 ? exq0.size() : exq1.size()) == 0) begin
        chk("valid_unexpected", 32'(crc_valid), 32'd0);
      end else if (!pcv) begin
        e = (owner == 0) ? exq0[0] : exq1[0];
        chk("crc_value", 32'(crc_value), 32'(e.crc));
        chk("byte_cnt", 32'(byte_cnt), 32'(e.cnt));
        chk("crc_src", 32'(crc_src), 32'(owner));
        chk("crc_err", 32'(crc_err), 32'(e.err));
        chk("last_to_valid", 32'(cyc), 32'(last_hs + 8));
        if (dense) chk("frame_cycles", 32'(cyc), 32'(first_hs + 9*(nb - 1) + 8));
        cap_crc = crc_value; cap_cnt = byte_cnt; cap_src = crc_src; cap_err = crc_err;
        hold_ctr = hold_len;
      end else begin
        chk("hold_crc", 32'(crc_value), 32'(cap_crc));
        chk("hold_cnt", 32'(byte_cnt), 32'(cap_cnt));
        chk("hold_src", 32'(crc_src), 32'(cap_src));
        chk("hold_err", 32'(crc_err), 32'(cap_err));
      end
    end
    drive();
  endtask

  task automatic run_frames(input int maxc);
    int c;
    c = 0;
    while ((txq0.size() + txq1.size() + exq0.size() + exq1.size()) != 0 && c < maxc) begin
      step();
      c++;
    end
    chk("drain_pending", 32'(exq0.size() + exq1.size()), 32'd0);
  endtask

  task automatic do_reset(input int ncyc);
    req_valid = '0; crc_ready = 1'b0; reset = 1'b1;
    repeat (ncyc) @(posedge clk);
    #1;
    cyc += ncyc;
    reset = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_crc_valid", 32'(crc_valid), 32'd0);
    chk("rst_crc_value", 32'(crc_value), 32'd0);
    chk("rst_crc_src", 32'(crc_src), 32'd0);
    chk("rst_byte_cnt", 32'(byte_cnt), 32'd0);
    chk("rst_crc_err", 32'(crc_err), 32'd0);
    txq0.delete(); txq1.delete(); exq0.delete(); exq1.delete();
    owner = -1; prio = 0; nb = 0; hold_ctr = 0;
  endtask

  initial begin
    req_valid = '0; req_data = '0; req_last = '0; crc_ready = 1'b0; reset = 1'b1;
    dense = 1'b1; rand_ready = 1'b0; hold_len = 0; hold_ctr = 0; nb = 0;
    first_hs = 0; last_hs = 0;
    do_reset(2);

    // Single-byte frames from each requester.
    fbuf = '{8'h01};
    push_frame(0, 1'b1, 16'hBAAD, 8'd1, 1'b0);
    run_frames(100);
    fbuf = '{8'h02};
    push_frame(1, 1'b1, 16'hCFF7, 8'd1, 1'b0);
    run_frames(100);

    // Four zero bytes back to back.
    fbuf = '{8'h00, 8'h00, 8'h00, 8'h00};
    push_frame(0, 1'b0, 16'h0, 8'h0, 1'b0);
    run_frames(200);

    // Both requesters busy: alternating grants, result held for 5 cycles.
    hold_len = 5;
    for (int f = 0; f < 6; f++) begin
      fbuf.delete();
      for (int b = 0; b < 2 + (f % 3); b++) fbuf.push_back(8'($urandom));
      push_frame(f % 2, 1'b0, 16'h0, 8'h0, 1'b0);
    end
    run_frames(1000);
    hold_len = 0;

    // Reset while shifting the second byte of a frame.
    fbuf = '{8'hAA, 8'hBB, 8'hCC};
    push_frame(0, 1'b0, 16'h0, 8'h0, 1'b0);
    for (int c = 0; c < 60 && nb < 2; c++) step();
    chk("reset_setup_bytes", 32'(nb), 32'd2);
    repeat (3) step();
    do_reset(1);
    fbuf = '{8'h01};
    push_frame(0, 1'b1, 16'hBAAD, 8'd1, 1'b0);
    run_frames(100);

`ifdef CRC16_CTRL_LEN_LIMIT_EN
    fbuf = '{8'h00, 8'h01, 8'hFF};
    push_frame(1, 1'b1, 16'hBAAD, 8'd2, 1'b1);
    run_frames(200);
`endif

    // Over-long frame: byte count wraps (or saturates with the length check).
    fbuf.delete();
    for (int b = 0; b < 257; b++) fbuf.push_back(8'($urandom));
    push_frame(1, 1'b0, 16'h0, 8'h0, 1'b0);
    run_frames(3000);

    // Randomized traffic with valid gaps and result back-pressure.
    dense = 1'b0; rand_ready = 1'b1;
    for (int f = 0; f < 24; f++) begin
      fbuf.delete();
      for (int b = 0; b < int'($urandom_range(1, 6)); b++) fbuf.push_back(8'($urandom));
      push_frame(int'($urandom_range(0, 1)), 1'b0, 16'h0, 8'h0, 1'b0);
    end
    run_frames(6000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
